// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and memory.
// master: the lsu drives request, write flag, address, byte enables, write data.
// slave : memory returns the completion strobe and read data.
interface lsu_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit for the RV32I execute stage.
// Accepts loads/stores from id/ex, runs one req/ack transaction on the data bus,
// holds the pipeline until the access completes, and returns extended load data.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   valid_i, inst_i    : live instruction (opcode/func3 decoded here)
//   addr_i, wdata_i    : effective address and rs2 store data
//   rd_addr_i          : load destination
//   bus                : data-memory bus (lsu_if.master)
//   rd_addr_o/rd_data_o/rd_wen_o : writeback, one-cycle pulse
//   hold_flag_o        : combinational pipeline hold to ctrl
//   misalign_o, bus_err_o : one-cycle exception pulses
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    lsu_if.master       bus,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        hold_flag_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 10;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              skip_q;
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        off_q;
    logic [BE_W-1:0]   be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        func3_q;
    logic [REG_W-1:0]  rd_addr_q;
    logic [XLEN-1:0]   rd_data_q;
    logic              rd_wen_q;
    logic              misalign_q;
    logic              bus_err_q;

    logic [6:0]        opcode_c;
    logic [2:0]        func3_c;
    logic              is_load_c;
    logic              is_store_c;
    logic              legal_c;
    logic              mis_c;
    logic              cand_c;
    logic              accept_c;
    logic              misalign_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_c;

    // Only opcode and func3 matter here; the rest of the instruction is decoded upstream.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_i[31:15], inst_i[11:7]};

    // Aligned extraction of load data from the returned bus word.
    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [XLEN-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    extract = {{24{b[7]}}, b};
            3'd1:    extract = {{16{h[15]}}, h};
            3'd4:    extract = {24'd0, b};
            3'd5:    extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    // Instruction decode, alignment check, lane steering.
    always_comb begin
        opcode_c   = inst_i[6:0];
        func3_c    = inst_i[14:12];
        is_load_c  = (opcode_c == OP_LOAD);
        is_store_c = (opcode_c == OP_STORE);
        legal_c    = 1'b0;
        if (is_load_c) begin
            legal_c = (func3_c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        if (is_store_c) begin
            legal_c = (func3_c inside {3'd0, 3'd1, 3'd2});
        end
        mis_c = ((func3_c[1:0] == 2'b01) && addr_i[0])
             || ((func3_c[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

        // The cycle after a misalign pulse is skipped so one instruction pulses once.
        cand_c     = (state_q == S_IDLE) && !skip_q && valid_i && legal_c;
        accept_c   = cand_c && !mis_c;
        misalign_c = cand_c && mis_c;

        case (func3_c[1:0])
            2'b00:   be_c = 4'b0001 << addr_i[1:0];
            2'b01:   be_c = addr_i[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
        case (func3_c[1:0])
            2'b00:   wdata_c = {4{wdata_i[7:0]}};
            2'b01:   wdata_c = {2{wdata_i[15:0]}};
            default: wdata_c = wdata_i;
        endcase

        cnt_d = cnt_q + CNT_W'(1);
    end

    // Control FSM with registered bus and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            skip_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            off_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            func3_q    <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_wen_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            rd_wen_q   <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            skip_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        state_q   <= S_WAIT;
                        cnt_q     <= '0;
                        req_q     <= 1'b1;
                        we_q      <= is_store_c;
                        addr_q    <= {addr_i[31:2], 2'b00};
                        off_q     <= addr_i[1:0];
                        be_q      <= be_c;
                        wdata_q   <= wdata_c;
                        func3_q   <= func3_c;
                        rd_addr_q <= rd_addr_i;
                    end else if (misalign_c) begin
                        misalign_q <= 1'b1;
                        skip_q     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Ack has priority over a timeout in the same cycle.
                    if (bus.mem_ack_i) begin
                        state_q   <= S_RESP;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        be_q      <= '0;
                        wdata_q   <= '0;
                        rd_data_q <= extract(func3_q, off_q, bus.mem_rdata_i);
                        rd_wen_q  <= !we_q && (rd_addr_q != '0);
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= S_RESP;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        be_q      <= '0;
                        wdata_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_wdata_o = wdata_q;
    assign rd_addr_o       = rd_addr_q;
    assign rd_data_o       = rd_data_q;
    assign rd_wen_o        = rd_wen_q;
    assign misalign_o      = misalign_q;
    assign bus_err_o       = bus_err_q;

    // Hold is combinational so the id/ex register freezes in the accept cycle itself.
    assign hold_flag_o = !rst && (accept_c || (state_q == S_WAIT));

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage of the RV32I core. It takes load/store instructions held in the id/ex register, uses the effective address the execute stage computes, and runs a request/acknowledge transaction on the data-memory bus. It holds the pipeline through the `ctrl` hold path until the access completes, then returns aligned, extended load data to the register file with a one-cycle write pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum WAIT cycles without `mem_ack_i` before the access is aborted. Legal range 2..1023.

Ports:
- `clk`  in  1: the only clock; everything samples on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `valid_i`  in  1: `inst_i` is a live, unflushed instruction.
- `inst_i`  in  32: the instruction. Opcode 0000011 is a load, 0100011 is a store; `func3` selects the access size.
- `addr_i`  in  32: effective address, base + offset, from the execute stage.
- `wdata_i`  in  32: store data, taken from rs2.
- `rd_addr_i`  in  5: load destination register.
- `mem_req_o`  out  1: bus request, level.
- `mem_we_o`  out  1: 1 for a store, 0 for a load.
- `mem_addr_o`  out  32: word-aligned address, `{addr[31:2], 2'b00}`.
- `mem_be_o`  out  4: byte enables.
- `mem_wdata_o`  out  32: lane-replicated store data.
- `mem_ack_i`  in  1: completion strobe from the bus; sampled only in WAIT.
- `mem_rdata_i`  in  32: read data; valid in the cycle `mem_ack_i` is high.
- `rd_addr_o`  out  5: writeback register.
- `rd_data_o`  out  32: writeback data.
- `rd_wen_o`  out  1: one-cycle writeback pulse.
- `hold_flag_o`  out  1: pipeline hold request to `ctrl`.
- `misalign_o`  out  1: one-cycle pulse when an access is misaligned.
- `bus_err_o`  out  1: one-cycle pulse when an access times out.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **Accept** in IDLE when `valid_i` is high, the opcode is load/store, `func3` is legal and the address is aligned.
  - Legal load `func3`: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Legal store `func3`: 0 SB, 1 SH, 2 SW.
  - On accept, register address, byte enables, write data, `func3`, rd and load/store type, then go to WAIT.
- **Illegal `func3`:** no-op. No bus access, no pulses, stay IDLE.
- **Misaligned access:** halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Pulse `misalign_o` for one cycle, with no bus access and no writeback.
  - Stay IDLE, but ignore inputs for the next cycle so the same instruction does not pulse twice.
- **Byte enables:**
  - SB/LB/LBU: `be = 4'b0001 << addr[1:0]`.
  - SH/LH/LHU: `be = addr[1] ? 4'b1100 : 4'b0011`.
  - SW/LW: `be = 4'b1111`.
- **Store data:** SB replicates `wdata_i[7:0]` into all four lanes; SH replicates `wdata_i[15:0]` into both halves; SW passes `wdata_i` unchanged.
- **WAIT:**
  - `mem_req_o` = 1, and all bus outputs stay stable until ack.
  - On `mem_ack_i`, capture `mem_rdata_i` and go to RESP.
  - The cycle counter increments every WAIT cycle. When it reaches `TIMEOUT_CYCLES`-1 with no ack, go to RESP flagged as an error.
  - If ack arrives in the same cycle as the timeout, ack wins.
- **RESP (one cycle):**
  - Load, no error, rd ≠ 0: `rd_wen_o` = 1 and `rd_data_o` = extracted data. For rd = 0 the access still happens, but no pulse.
  - Error: `bus_err_o` = 1 and `rd_wen_o` = 0.
  - Store: no pulse.
  - Always go to IDLE next; inputs are ignored in RESP.
- **Load data extraction:** select the byte lane from `addr[1:0]`, or the halfword from `addr[1]`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- **`hold_flag_o`:** combinational 1 when in IDLE and an accept condition is true, or when in WAIT; 0 in RESP and otherwise.
- **`mem_ack_i` outside WAIT** is ignored.

## Timing
- **Reset values:** state IDLE, counter 0, and every output 0 (`mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `rd_addr_o`, `rd_data_o`, `rd_wen_o`, `misalign_o`, `bus_err_o`, `hold_flag_o`).
- **Cycle sequence:**
  - T0: accept; `hold_flag_o` = 1 combinationally.
  - T1: first `mem_req_o` cycle.
  - Ack at Tk (k ≥ 1) puts RESP at Tk+1.
  - Minimum latency from accept to writeback pulse: 2 cycles.
- **Pipeline advance:** the pipeline is frozen T0..Tk. `hold_flag_o` is 0 in RESP, so the id/ex register advances at the end of RESP.
- **Timeout:** with no ack, RESP with `bus_err_o` follows exactly `TIMEOUT_CYCLES` cycles after the first `mem_req_o` cycle.
- **`rst` in any state:** next cycle is IDLE with all outputs 0. `mem_req_o` drops and no pulse is issued for the aborted access.
- **Outputs:** all outputs except `hold_flag_o` are registered.

## Test plan
- **LW, 0 wait states:** `addr_i` = 0x100, rd = 5, ack at T1 with rdata 0xDEADBEEF -> `mem_addr_o` = 0x100, `be` = 1111, `rd_wen_o` pulse at T2 with rd 5 / 0xDEADBEEF, `hold_flag_o` high T0..T1.
- **LB / LBU:** `addr_i` = 0x203, rdata 0x80FF0011 -> LB gives 0xFFFFFF80; LBU gives 0x00000080; `be` = 1000.
- **SH:** `addr_i` = 0x42, `wdata_i` = 0x1234ABCD, ack after 3 waits -> `mem_we_o` = 1, `be` = 1100, `mem_wdata_o` = 0xABCDABCD, `mem_addr_o` = 0x40 stable through WAIT, no `rd_wen_o`.
- **Misaligned and illegal:** LW at 0x101 -> one `misalign_o` pulse, `mem_req_o` stays 0, `hold_flag_o` stays 0. Load with `func3` = 3 -> nothing happens.
- **Timeout and race:** `TIMEOUT_CYCLES` = 4, no ack -> `bus_err_o` pulse exactly 4 cycles after the first request, no writeback. Repeat with ack on the 4th cycle -> normal writeback, no error.
- **Reset mid-WAIT:** `rst` in the 2nd WAIT cycle -> next cycle all outputs 0 and IDLE. A late ack is ignored, and no `rd_wen_o` is produced.
